// File: rtl/simple_alu_operand_stage_pkg.sv
// Shared widths and packet types for the simple ALU register-read / operand-select stage.
// The fuPkt layout is shared with issue and the ALU; the entry struct is local to this stage.
package simple_alu_operand_stage_pkg;

   localparam int SIZE_DATA           = 64;
   localparam int SIZE_PHYSICAL_LOG   = 7;
   localparam int SIZE_IMMEDIATE      = 32;
   localparam int NUM_BYPASS          = 4;
   localparam int SIZE_PC             = 32;
   localparam int SIZE_INSTRUCTION    = 32;
   localparam int SIZE_LOGICAL_LOG    = 5;
   localparam int SIZE_ACTIVELIST_LOG = 6;
   localparam int SIZE_SEQ            = 8;

   typedef struct packed {
      logic [SIZE_SEQ-1:0]            seqNo;
      logic [SIZE_PC-1:0]             pc;
      logic [SIZE_INSTRUCTION-1:0]    inst;
      logic [SIZE_LOGICAL_LOG-1:0]    logDest;
      logic [SIZE_PHYSICAL_LOG-1:0]   phyDest;
      logic                           phyDestValid;
      logic [SIZE_ACTIVELIST_LOG-1:0] alID;
      logic                           valid;
   } fuPkt;

   // One captured issue: packet plus operands, frozen at capture time.
   typedef struct packed {
      fuPkt                      pkt;
      logic [SIZE_DATA-1:0]      data1;
      logic [SIZE_DATA-1:0]      data2;
      logic [SIZE_IMMEDIATE-1:0] immd;
   } stage_entry_t;

endpackage

// File: rtl/simple_alu_operand_stage_bypass_mux.sv
// Resolves one source operand: unused source -> 0, else lowest-index matching
// valid bypass entry, else register-file data.
module operand_bypass_mux
   import simple_alu_operand_stage_pkg::*;
(
   input  logic                                  src_valid,
   input  logic [SIZE_PHYSICAL_LOG-1:0]          src_tag,
   input  logic [SIZE_DATA-1:0]                  rf_data,
   input  logic [NUM_BYPASS-1:0]                 bypass_valid,
   input  logic [NUM_BYPASS*SIZE_PHYSICAL_LOG-1:0] bypass_tag,
   input  logic [NUM_BYPASS*SIZE_DATA-1:0]       bypass_data,
   output logic [SIZE_DATA-1:0]                  operand
);

   always_comb begin
      operand = rf_data;
      // Walk from the lowest priority upward so the last hit (lowest index) wins.
      for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
         if (bypass_valid[i] &&
             (bypass_tag[i*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] == src_tag)) begin
            operand = bypass_data[i*SIZE_DATA +: SIZE_DATA];
         end
      end
      if (!src_valid) begin
         operand = '0;
      end
   end

endmodule

// File: rtl/simple_alu_operand_stage.sv
// Operand-select stage ahead of the simple ALU: resolves sources against the
// bypass network at capture and holds results in a main + skid entry pair.
module simple_alu_operand_stage
   import simple_alu_operand_stage_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    recoverFlag_i,
   input  logic                                    inValid_i,
   output logic                                    inReady_o,
   input  fuPkt                                    inPacket_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]            src1Tag_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0]            src2Tag_i,
   input  logic                                    src1Valid_i,
   input  logic                                    src2Valid_i,
   input  logic [SIZE_DATA-1:0]                    rf1Data_i,
   input  logic [SIZE_DATA-1:0]                    rf2Data_i,
   input  logic [SIZE_IMMEDIATE-1:0]               immd_i,
   input  logic [NUM_BYPASS-1:0]                   bypassValid_i,
   input  logic [NUM_BYPASS*SIZE_PHYSICAL_LOG-1:0] bypassTag_i,
   input  logic [NUM_BYPASS*SIZE_DATA-1:0]         bypassData_i,
   output logic                                    outValid_o,
   input  logic                                    outReady_i,
   output fuPkt                                    exePacket_o,
   output logic [SIZE_DATA-1:0]                    data1_o,
   output logic [SIZE_DATA-1:0]                    data2_o,
   output logic [SIZE_IMMEDIATE-1:0]               immd_o
);

   // Handshake: an input transfers when inValid_i && inReady_o && !recoverFlag_i
   // at a rising edge; an output transfers when outValid_o && outReady_i. inReady_o
   // is purely registered (not skid full), so outReady_i never reaches it combinationally.

   stage_entry_t          capture;
   stage_entry_t          main_q;
   stage_entry_t          skid_q;
   logic                  main_valid;
   logic                  skid_valid;
   logic [SIZE_DATA-1:0]  src1_operand;
   logic [SIZE_DATA-1:0]  src2_operand;
   logic                  accept;
   logic                  drain;

   operand_bypass_mux u_src1_mux (
      .src_valid    (src1Valid_i),
      .src_tag      (src1Tag_i),
      .rf_data      (rf1Data_i),
      .bypass_valid (bypassValid_i),
      .bypass_tag   (bypassTag_i),
      .bypass_data  (bypassData_i),
      .operand      (src1_operand)
   );

   operand_bypass_mux u_src2_mux (
      .src_valid    (src2Valid_i),
      .src_tag      (src2Tag_i),
      .rf_data      (rf2Data_i),
      .bypass_valid (bypassValid_i),
      .bypass_tag   (bypassTag_i),
      .bypass_data  (bypassData_i),
      .operand      (src2_operand)
   );

   assign capture.pkt   = inPacket_i;
   assign capture.data1 = src1_operand;
   assign capture.data2 = src2_operand;
   assign capture.immd  = immd_i;

   assign inReady_o = !skid_valid;
   assign accept    = inValid_i && inReady_o && !recoverFlag_i;
   assign drain     = main_valid && outReady_i;

   always_ff @(posedge clk) begin
      if (reset || recoverFlag_i) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid || drain) begin
         // Main is free this edge: the older skid entry has precedence over new input.
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (accept) begin
            main_q     <= capture;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= capture;
         skid_valid <= 1'b1;
      end
   end

   assign outValid_o  = main_valid;
   assign exePacket_o = main_valid ? main_q.pkt   : '0;
   assign data1_o     = main_valid ? main_q.data1 : '0;
   assign data2_o     = main_valid ? main_q.data2 : '0;
   assign immd_o      = main_valid ? main_q.immd  : '0;

endmodule
